// File: rtl/ch_est_lsi_multi_ant.sv
// NB-IoT NRS channel estimator: per-lane LS at two pilots, optional time averaging,
// linear interpolation over 12 subcarriers streamed out with valid/ready.
module ch_est_lsi_multi_ant #(
  parameter int NUM_ANT   = 1,
  parameter int WIDTH_RX  = 16,
  parameter int OUT_WIDTH = 17,
  parameter int AVG_LOG2  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           avg_mode,
  input  logic [2:0]                     v_shift,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_ANT*WIDTH_RX-1:0]    in_rx_r,
  input  logic [NUM_ANT*WIDTH_RX-1:0]    in_rx_i,
  input  logic [1:0]                     in_nrs,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [3:0]                     out_sc,
  output logic                           out_last,
  output logic [NUM_ANT*OUT_WIDTH-1:0]   out_h_r,
  output logic [NUM_ANT*OUT_WIDTH-1:0]   out_h_i
);

  localparam int EW  = WIDTH_RX + 1;
  localparam int EW1 = EW + 1;
  localparam int EWX = EW + 10;
  localparam int AW  = EW + AVG_LOG2;
  localparam int SW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [SW-1:0] SYM_LAST = SW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACC    = 2'd1,
    S_EST    = 2'd2,
    S_INTERP = 2'd3
  } state_t;

  function automatic logic signed [EW-1:0] rx_ext(input logic [WIDTH_RX-1:0] x);
    rx_ext = EW'($signed(x));
  endfunction

  function automatic logic signed [EW-1:0] neg_sel(input logic neg, input logic signed [EW-1:0] x);
    neg_sel = neg ? -x : x;
  endfunction

  function automatic logic [7:0] interp_weight(input logic [3:0] d);
    case (d)
      4'd1:    interp_weight = 8'd43;
      4'd2:    interp_weight = 8'd85;
      4'd3:    interp_weight = 8'd128;
      4'd4:    interp_weight = 8'd171;
      4'd5:    interp_weight = 8'd213;
      default: interp_weight = 8'd0;
    endcase
  endfunction

  // Weights are k/6 in Q8; the floor shift keeps the result between E0 and E1.
  function automatic logic signed [OUT_WIDTH-1:0] interp_point(
    input logic signed [EW-1:0] e0,
    input logic signed [EW-1:0] e1,
    input logic [3:0]           k,
    input logic [2:0]           v
  );
    logic signed [EW1-1:0] diff;
    logic signed [EWX-1:0] wt_x;
    logic signed [EW-1:0]  res;
    diff = EW1'(e1) - EW1'(e0);
    wt_x = $signed({{(EW + 2){1'b0}}, interp_weight(k - {1'b0, v})});
    res  = EW'(EWX'(e0) + ((EWX'(diff) * wt_x) >>> 4'd8));
    if (k <= {1'b0, v}) begin
      interp_point = OUT_WIDTH'(e0);
    end else if (k >= ({1'b0, v} + 4'd6)) begin
      interp_point = OUT_WIDTH'(e1);
    end else begin
      interp_point = OUT_WIDTH'(res);
    end
  endfunction

  state_t                 state_q, state_d;
  logic                   pil_q, pil_d;
  logic [SW-1:0]          sym_q, sym_d;
  logic                   mode_q, mode_d;
  logic [2:0]             v_q, v_d;
  logic [3:0]             sc_q, sc_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic [NUM_ANT*OUT_WIDTH-1:0] out_h_r_q, out_h_r_d;
  logic [NUM_ANT*OUT_WIDTH-1:0] out_h_i_q, out_h_i_d;
  logic signed [AW-1:0]   acc_q [NUM_ANT][2][2];
  logic signed [AW-1:0]   acc_d [NUM_ANT][2][2];
  logic signed [EW-1:0]   e_q   [NUM_ANT][2][2];
  logic signed [EW-1:0]   e_d   [NUM_ANT][2][2];
  logic signed [EW-1:0]   ls_re_s [NUM_ANT];
  logic signed [EW-1:0]   ls_im_s [NUM_ANT];
  logic                   in_fire_s;
  logic                   last_sym_s;
  logic                   clear_s;
  logic [3:0]             load_k_s;
  logic [2:0]             v_mod_s;

  // Per-lane LS product rx*conj(nrs) with the 1/sqrt2 scale dropped.
  always_comb begin
    for (int n = 0; n < NUM_ANT; n++) begin
      ls_re_s[n] = neg_sel(in_nrs[1], rx_ext(in_rx_r[n*WIDTH_RX +: WIDTH_RX]))
                 + neg_sel(in_nrs[0], rx_ext(in_rx_i[n*WIDTH_RX +: WIDTH_RX]));
      ls_im_s[n] = neg_sel(in_nrs[1], rx_ext(in_rx_i[n*WIDTH_RX +: WIDTH_RX]))
                 - neg_sel(in_nrs[0], rx_ext(in_rx_r[n*WIDTH_RX +: WIDTH_RX]));
    end
  end

  // Frame FSM, accumulation, estimate latch and output stream.
  always_comb begin
    state_d     = state_q;
    pil_d       = pil_q;
    sym_d       = sym_q;
    mode_d      = mode_q;
    v_d         = v_q;
    sc_d        = sc_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_h_r_d   = out_h_r_q;
    out_h_i_d   = out_h_i_q;
    acc_d       = acc_q;
    e_d         = e_q;
    clear_s     = flush;
    in_fire_s   = in_valid & in_ready_q & ((state_q == S_IDLE) | (state_q == S_ACC));
    last_sym_s  = ~mode_q | (sym_q == SYM_LAST);
    load_k_s    = out_valid_q ? (sc_q + 4'd1) : 4'd0;
    v_mod_s     = (v_shift >= 3'd6) ? (v_shift - 3'd6) : v_shift;

    case (state_q)
      S_IDLE, S_ACC: begin
        if (in_fire_s) begin
          if (state_q == S_IDLE) begin
            mode_d = avg_mode;
            v_d    = v_mod_s;
          end else begin
            mode_d = mode_q;
            v_d    = v_q;
          end
          for (int n = 0; n < NUM_ANT; n++) begin
            acc_d[n][pil_q][0] = acc_q[n][pil_q][0] + AW'(ls_re_s[n]);
            acc_d[n][pil_q][1] = acc_q[n][pil_q][1] + AW'(ls_im_s[n]);
          end
          if (pil_q) begin
            pil_d = 1'b0;
            if (last_sym_s) begin
              sym_d   = '0;
              state_d = S_EST;
            end else begin
              sym_d   = sym_q + SW'(1);
              state_d = S_ACC;
            end
          end else begin
            pil_d   = 1'b1;
            state_d = S_ACC;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_EST: begin
        for (int n = 0; n < NUM_ANT; n++) begin
          for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 2; c++) begin
              e_d[n][p][c] = mode_q ? EW'(acc_q[n][p][c] >>> AVG_LOG2) : EW'(acc_q[n][p][c]);
            end
          end
        end
        state_d = S_INTERP;
      end
      S_INTERP: begin
        if (!out_valid_q || out_ready) begin
          if (out_valid_q && out_last_q) begin
            clear_s = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            sc_d        = load_k_s;
            out_last_d  = (load_k_s == 4'd11);
            for (int n = 0; n < NUM_ANT; n++) begin
              out_h_r_d[n*OUT_WIDTH +: OUT_WIDTH] = interp_point(e_q[n][0][0], e_q[n][1][0], load_k_s, v_q);
              out_h_i_d[n*OUT_WIDTH +: OUT_WIDTH] = interp_point(e_q[n][0][1], e_q[n][1][1], load_k_s, v_q);
            end
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Frame end and flush share one wipe; a sample presented with flush is lost here.
    if (clear_s) begin
      state_d     = S_IDLE;
      pil_d       = 1'b0;
      sym_d       = '0;
      mode_d      = 1'b0;
      v_d         = 3'd0;
      sc_d        = 4'd0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_h_r_d   = '0;
      out_h_i_d   = '0;
      for (int n = 0; n < NUM_ANT; n++) begin
        for (int p = 0; p < 2; p++) begin
          for (int c = 0; c < 2; c++) begin
            acc_d[n][p][c] = '0;
            e_d[n][p][c]   = '0;
          end
        end
      end
    end else begin
      state_d = state_d;
    end

    in_ready_d = (state_d == S_IDLE) || (state_d == S_ACC);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pil_q       <= 1'b0;
      sym_q       <= '0;
      mode_q      <= 1'b0;
      v_q         <= 3'd0;
      sc_q        <= 4'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_h_r_q   <= '0;
      out_h_i_q   <= '0;
      for (int n = 0; n < NUM_ANT; n++) begin
        for (int p = 0; p < 2; p++) begin
          for (int c = 0; c < 2; c++) begin
            acc_q[n][p][c] <= '0;
            e_q[n][p][c]   <= '0;
          end
        end
      end
    end else begin
      state_q     <= state_d;
      pil_q       <= pil_d;
      sym_q       <= sym_d;
      mode_q      <= mode_d;
      v_q         <= v_d;
      sc_q        <= sc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_h_r_q   <= out_h_r_d;
      out_h_i_q   <= out_h_i_d;
      acc_q       <= acc_d;
      e_q         <= e_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sc    = sc_q;
  assign out_last  = out_last_q;
  assign out_h_r   = out_h_r_q;
  assign out_h_i   = out_h_i_q;

endmodule
